// File: rtl/sys_defs.sv
// sys_defs: shared front-end definitions.
//   IF_ID              - fetch/decode pipeline bundle entry (valid, thread_ID, NPC, IR).
//   DEFAULT_FIFO_DEPTH - default number of entries in each per-thread buffer.
//   count_valid()      - number of valid slots in a two-slot bundle.
package sys_defs;

  localparam int DEFAULT_FIFO_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic        thread_ID;
    logic [31:0] NPC;
    logic [31:0] IR;
  } IF_ID;

  // Number of valid slots in a two-slot bundle (0..2).
  function automatic logic [1:0] count_valid(input IF_ID [1:0] b);
    case ({b[1].valid, b[0].valid})
      2'b00:        return 2'd0;
      2'b01, 2'b10: return 2'd1;
      2'b11:        return 2'd2;
      default:      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: circular instruction FIFO for one hardware thread.
//   clock, reset - system clock, synchronous active-high reset
//   flush        - empties the FIFO at the edge; overrides push and pop
//   push_cnt     - number of entries (0..2) taken from push_data[0], [1]
//   push_data    - entries to append, oldest in slot 0
//   pop_cnt      - number of entries (0..2) to retire from the head
//   peek         - raw head and head+1 entries (caller masks by count)
//   count        - current occupancy
// The caller guarantees push_cnt never exceeds free space and pop_cnt never
// exceeds count.
module inst_fifo
  import sys_defs::*;
#(
  parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  IF_ID [1:0]    push_data,
  input  logic [1:0]    pop_cnt,
  output IF_ID [1:0]    peek,
  output logic [CW-1:0] count
);

  IF_ID          mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  // Pointer and occupancy update; pointers wrap naturally at PW bits.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PW'(pop_cnt);
      tail_r  <= tail_r + PW'(push_cnt);
      count_r <= count_r + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      if (push_cnt != 2'd0) begin
        mem_r[tail_r] <= push_data[0];
      end
      if (push_cnt == 2'd2) begin
        mem_r[tail_r + PW'(1)] <= push_data[1];
      end
    end
  end

  assign peek[0] = mem_r[head_r];
  assign peek[1] = mem_r[head_r + PW'(1)];
  assign count   = count_r;

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: two-thread instruction buffer between fetch and decode.
//   clock, reset        - system clock, synchronous active-high reset
//   mispredict_thread_0 - flush thread 0 buffer
//   mispredict_thread_1 - flush thread 1 buffer
//   fetch_in            - up to two fetched instructions of one thread, slot 0 older
//   id_stall            - decode cannot accept this cycle
//   inst_out            - up to two same-thread instructions for decode, slot 0 older
//   fetch_stall         - bit t: thread t buffer has fewer than two free entries
//   free_count          - free entries per thread
module if_id_buffer
  import sys_defs::*;
#(
  parameter  int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mispredict_thread_0,
  input  logic                mispredict_thread_1,
  input  IF_ID [1:0]          fetch_in,
  input  logic                id_stall,
  output IF_ID [1:0]          inst_out,
  output logic [1:0]          fetch_stall,
  output logic [1:0][CW-1:0]  free_count
);

  logic [1:0]    flush_s;
  logic [CW-1:0] count_s     [2];
  IF_ID [1:0]    peek_s      [2];
  logic [1:0]    push_cnt_s  [2];
  IF_ID [1:0]    push_data_s [2];
  logic [1:0]    pop_cnt_s   [2];
  logic          enq_thread_s;
  logic          other_thread_s;
  logic          sel_thread_s;
  logic          sel_ok_s;
  logic          out_thread_s;
  IF_ID [1:0]    live_s;
  IF_ID [1:0]    out_s;
  IF_ID [1:0]    held_r;
  logic          held_thread_r;
  logic          hold_r;
  logic          last_thread_r;

  assign flush_s = {mispredict_thread_1, mispredict_thread_0};

  for (genvar t = 0; t < 2; t++) begin : g_thread
    inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush_s[t]),
      .push_cnt  (push_cnt_s[t]),
      .push_data (push_data_s[t]),
      .pop_cnt   (pop_cnt_s[t]),
      .peek      (peek_s[t]),
      .count     (count_s[t])
    );
    // Backpressure looks only at current occupancy, ignoring same-cycle pops.
    assign fetch_stall[t] = (count_s[t] > CW'(FIFO_DEPTH - 2));
    assign free_count[t]  = CW'(FIFO_DEPTH) - count_s[t];
  end

  // Enqueue steering: compact the bundle so a lone slot-1 instruction lands first.
  always_comb begin
    push_cnt_s[0]  = 2'd0;
    push_cnt_s[1]  = 2'd0;
    push_data_s[0] = '0;
    push_data_s[1] = '0;
    enq_thread_s   = fetch_in[0].thread_ID;
    if (!fetch_stall[enq_thread_s]) begin
      push_cnt_s[enq_thread_s] = count_valid(fetch_in);
      if (fetch_in[0].valid) begin
        push_data_s[enq_thread_s] = fetch_in;
      end else begin
        push_data_s[enq_thread_s][0] = fetch_in[1];
      end
    end else begin
      push_cnt_s[enq_thread_s] = 2'd0;
    end
  end

  // Round-robin thread choice and the live (unstalled) output bundle.
  always_comb begin
    other_thread_s = ~last_thread_r;
    sel_thread_s   = other_thread_s;
    sel_ok_s       = 1'b0;
    live_s         = '0;
    if (count_s[other_thread_s] != CW'(0)) begin
      sel_thread_s = other_thread_s;
      sel_ok_s     = 1'b1;
    end else if (count_s[last_thread_r] != CW'(0)) begin
      sel_thread_s = last_thread_r;
      sel_ok_s     = 1'b1;
    end else begin
      sel_ok_s     = 1'b0;
    end
    if (sel_ok_s) begin
      live_s[0] = peek_s[sel_thread_s][0];
      if (count_s[sel_thread_s] >= CW'(2)) begin
        live_s[1] = peek_s[sel_thread_s][1];
      end else begin
        live_s[1] = '0;
      end
    end else begin
      live_s = '0;
    end
  end

  // Shown bundle (held copy while decode stalls) and the matching dequeue.
  always_comb begin
    pop_cnt_s[0] = 2'd0;
    pop_cnt_s[1] = 2'd0;
    out_s        = hold_r ? held_r : live_s;
    out_thread_s = hold_r ? held_thread_r : sel_thread_s;
    if (!id_stall && out_s[0].valid) begin
      pop_cnt_s[out_thread_s] = count_valid(out_s);
    end else begin
      pop_cnt_s[out_thread_s] = 2'd0;
    end
  end

  // Round-robin history and stall hold; a flush of the shown thread drops the hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_thread_r <= 1'b1;
      hold_r        <= 1'b0;
      held_r        <= '0;
      held_thread_r <= 1'b0;
    end else if (id_stall) begin
      hold_r        <= !(out_s[0].valid && flush_s[out_thread_s]);
      held_r        <= out_s;
      held_thread_r <= out_thread_s;
    end else begin
      hold_r <= 1'b0;
      if (out_s[0].valid) begin
        last_thread_r <= out_thread_s;
      end
    end
  end

  assign inst_out = out_s;

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed scenarios plus randomized traffic for if_id_buffer,
// checked every cycle against a queue-based reference model.
module tb_if_id_buffer;
  import sys_defs::*;

  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  typedef IF_ID [1:0] bundle_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              mp0, mp1, id_stall;
  bundle_t           fetch_in;
  bundle_t           inst_out;
  logic [1:0]        fetch_stall;
  logic [1:0][CW-1:0] free_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  IF_ID    q0[$];
  IF_ID    q1[$];
  bit      last_m;
  bit      hold_m;
  bundle_t exp_out;
  logic [31:0] npc_ctr [2];

  always #5 clock = ~clock;

  if_id_buffer #(.FIFO_DEPTH(D)) dut (
    .clock               (clock),
    .reset               (reset),
    .mispredict_thread_0 (mp0),
    .mispredict_thread_1 (mp1),
    .fetch_in            (fetch_in),
    .id_stall            (id_stall),
    .inst_out            (inst_out),
    .fetch_stall         (fetch_stall),
    .free_count          (free_count)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bundle_t mk(bit t, logic [31:0] a, logic [31:0] b, logic [1:0] v);
    bundle_t r;
    r = '0;
    r[0].thread_ID = t;
    r[1].thread_ID = t;
    if (v[0]) begin r[0].valid = 1'b1; r[0].NPC = a; r[0].IR = a ^ 32'hA5A5_0000; end
    if (v[1]) begin r[1].valid = 1'b1; r[1].NPC = b; r[1].IR = b ^ 32'h0000_5A5A; end
    return r;
  endfunction

  function automatic int qlen(bit t);
    return t ? q1.size() : q0.size();
  endfunction

  function automatic IF_ID qat(bit t, int i);
    return t ? q1[i] : q0[i];
  endfunction

  task automatic qpush(bit t, IF_ID e);
    if (t) q1.push_back(e); else q0.push_back(e);
  endtask

  task automatic qpop(bit t);
    if (t) void'(q1.pop_front()); else void'(q0.pop_front());
  endtask

  // Prefer the thread not served last; fall back to the last one.
  task automatic compute_live();
    bit sel;
    int n;
    exp_out = '0;
    sel = (qlen(!last_m) > 0) ? !last_m : last_m;
    n = qlen(sel);
    if (n >= 1) exp_out[0] = qat(sel, 0);
    if (n >= 2) exp_out[1] = qat(sel, 1);
  endtask

  task automatic check_all(input string tag);
    logic [1:0][CW-1:0] ef;
    logic [1:0]         es;
    ef[0] = CW'(D - q0.size());
    ef[1] = CW'(D - q1.size());
    es[0] = (q0.size() > D - 2);
    es[1] = (q1.size() > D - 2);
    check_val({tag, "_inst_out"}, inst_out, exp_out);
    check_val({tag, "_free_count"}, free_count, ef);
    check_val({tag, "_fetch_stall"}, fetch_stall, es);
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input string tag, input bundle_t f, input bit st, input bit m0, input bit m1);
    bundle_t e;
    bit      t;
    bit      fl [2];
    int      cnt;
    fetch_in = f; id_stall = st; mp0 = m0; mp1 = m1;
    @(posedge clock);
    e = exp_out;
    fl[0] = m0; fl[1] = m1;
    t = f[0].thread_ID;
    cnt = qlen(t);
    if (!st && e[0].valid) begin
      if (!fl[e[0].thread_ID]) begin
        qpop(e[0].thread_ID);
        if (e[1].valid) qpop(e[0].thread_ID);
      end
      last_m = e[0].thread_ID;
    end
    if (cnt <= D - 2 && !fl[t]) begin
      if (f[0].valid) qpush(t, f[0]);
      if (f[1].valid) qpush(t, f[1]);
    end
    if (m0) q0.delete();
    if (m1) q1.delete();
    if (st) hold_m = !(e[0].valid && fl[e[0].thread_ID]);
    else    hold_m = 1'b0;
    if (hold_m) exp_out = e;
    else        compute_live();
    #1;
    check_all(tag);
  endtask

  bundle_t nop;

  initial begin
    nop = '0;
    reset = 1'b1; mp0 = 1'b0; mp1 = 1'b0; id_stall = 1'b0; fetch_in = '0;
    q0.delete(); q1.delete();
    last_m = 1'b1; hold_m = 1'b0; exp_out = '0;
    npc_ctr[0] = 32'h0001_0000; npc_ctr[1] = 32'h0002_0000;
    repeat (2) @(posedge clock);
    #1;
    check_val("reset_inst_out", inst_out, 136'd0);
    check_val("reset_fetch_stall", fetch_stall, 136'd0);
    check_val("reset_free0", free_count[0], 136'(D));
    check_val("reset_free1", free_count[1], 136'(D));
    reset = 1'b0;

    // Basic latency: two thread-0 instructions appear next cycle, then leave.
    step("t1_push", mk(1'b0, 32'd4, 32'd8, 2'b11), 1'b0, 1'b0, 1'b0);
    check_val("t1_npc0", inst_out[0].NPC, 136'd4);
    check_val("t1_npc1", inst_out[1].NPC, 136'd8);
    check_val("t1_valid", {inst_out[1].valid, inst_out[0].valid}, 136'd3);
    step("t1_drain", nop, 1'b0, 1'b0, 1'b0);
    check_val("t1_empty", {inst_out[1].valid, inst_out[0].valid}, 136'd0);

    // Alternating threads: output thread alternates, never mixed.
    step("alt0", mk(1'b0, 32'd12, 32'd16, 2'b11), 1'b0, 1'b0, 1'b0);
    check_val("alt0_thr", {inst_out[1].thread_ID, inst_out[0].thread_ID}, 136'd0);
    step("alt1", mk(1'b1, 32'd20, 32'd24, 2'b11), 1'b0, 1'b0, 1'b0);
    check_val("alt1_thr", {inst_out[1].thread_ID, inst_out[0].thread_ID}, 136'd3);
    step("alt2", mk(1'b0, 32'd28, 32'd32, 2'b11), 1'b0, 1'b0, 1'b0);
    check_val("alt2_thr", {inst_out[1].thread_ID, inst_out[0].thread_ID}, 136'd0);
    step("alt_drain", nop, 1'b0, 1'b0, 1'b0);

    // Fill thread 1 to 7 while decode stalls; a further push is dropped.
    step("fill_a", mk(1'b1, 32'd40, 32'd44, 2'b11), 1'b1, 1'b0, 1'b0);
    step("fill_b", mk(1'b1, 32'd48, 32'd52, 2'b11), 1'b1, 1'b0, 1'b0);
    step("fill_c", mk(1'b1, 32'd56, 32'd60, 2'b11), 1'b1, 1'b0, 1'b0);
    step("fill_d", mk(1'b1, 32'd64, 32'd0, 2'b01), 1'b1, 1'b0, 1'b0);
    check_val("fill_free1", free_count[1], 136'd1);
    check_val("fill_stall1", fetch_stall[1], 136'd1);
    step("fill_drop", mk(1'b1, 32'd68, 32'd72, 2'b11), 1'b1, 1'b0, 1'b0);
    check_val("fill_drop_free1", free_count[1], 136'd1);
    repeat (6) step("fill_drain", nop, 1'b0, 1'b0, 1'b0);

    // Decode stall for three cycles with three thread-0 entries.
    step("stall_a", mk(1'b0, 32'd100, 32'd104, 2'b11), 1'b0, 1'b0, 1'b0);
    step("stall_b", mk(1'b0, 32'd108, 32'd0, 2'b01), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step("stall_hold", nop, 1'b1, 1'b0, 1'b0);
      check_val("stall_hold_npc0", inst_out[0].NPC, 136'd100);
      check_val("stall_hold_npc1", inst_out[1].NPC, 136'd104);
    end
    step("stall_rel", nop, 1'b0, 1'b0, 1'b0);
    check_val("stall_rel_npc0", inst_out[0].NPC, 136'd108);
    check_val("stall_rel_v1", inst_out[1].valid, 136'd0);
    step("stall_drain", nop, 1'b0, 1'b0, 1'b0);

    // Flush thread 0 together with a thread-0 push; thread 1 untouched.
    step("fl_t1", mk(1'b1, 32'd200, 32'd204, 2'b11), 1'b1, 1'b0, 1'b0);
    step("fl_mp0", mk(1'b0, 32'd300, 32'd304, 2'b11), 1'b0, 1'b1, 1'b0);
    check_val("fl_free0", free_count[0], 136'(D));
    check_val("fl_thr", inst_out[0].thread_ID, 136'd1);
    check_val("fl_npc0", inst_out[0].NPC, 136'd200);
    check_val("fl_npc1", inst_out[1].NPC, 136'd204);
    step("fl_drain", nop, 1'b0, 1'b0, 1'b0);

    // Pointer wrap: 20 single instructions stream through thread 0.
    for (int i = 0; i < 20; i++) begin
      step("wrap", mk(1'b0, 32'(1000 + 4 * i), 32'd0, 2'b01), 1'b0, 1'b0, 1'b0);
      check_val("wrap_npc", inst_out[0].NPC, 136'(1000 + 4 * i));
    end
    step("wrap_drain", nop, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit          t;
      logic [1:0]  v;
      logic [31:0] a, b;
      t = 1'($urandom_range(0, 1));
      v = 2'($urandom_range(0, 3));
      a = 32'd0; b = 32'd0;
      if (v[0]) begin a = npc_ctr[t]; npc_ctr[t] = npc_ctr[t] + 32'd4; end
      if (v[1]) begin b = npc_ctr[t]; npc_ctr[t] = npc_ctr[t] + 32'd4; end
      step("rand", mk(t, a, b, v),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 19) == 0));
    end
    repeat (12) step("final_drain", nop, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
